gate_pair_monitor: RTL and testbench
====================================

// Module: gate_pair_monitor
// PURPOSE
//  Receive-side checker for a complementary gate pair (A = high side, B = low side), as emitted by the dead-time stage.
//  Recovers the original PWM, measures every dead-time gap, times period and high time, and flags dead-time
//  violations and shoot-through. Sits between gate pins (looped back) and the PS register block.
// PARAMETERS
//  CNT_W        8   width of dead-time counters, dt_meas_* and dtmin_*
//  PER_W        16  width of period/high-time counters
//  SYNC_STAGES  2   synchronizer depth on gate_A/gate_B (>=2)
// PORTS
//  clk          in   1      system clock
//  reset        in   1      asynchronous, active-high
//  gate_A       in   1      raw high-side gate signal (async to clk)
//  gate_B       in   1      raw low-side gate signal (async to clk)
//  logic_A      in   1      polarity of gate_A: active = gate_A ^ logic_A
//  logic_B      in   1      polarity of gate_B: active = gate_B ^ logic_B
//  pwm_onoff    in   _pwm_onoff  monitor enable; off => idle, no fault capture
//  dtmin_A      in   CNT_W  minimum legal gap before A turns on (cycles)
//  dtmin_B      in   CNT_W  minimum legal gap before B turns on (cycles)
//  fault_clr    in   1      sync pulse: clears sticky fault flags
//  pwm_rec      out  1      recovered PWM
//  dt_meas_A    out  CNT_W  last measured gap B-off -> A-on
//  dt_meas_B    out  CNT_W  last measured gap A-off -> B-on
//  dt_valid_A   out  1      1-cycle pulse: dt_meas_A updated
//  dt_valid_B   out  1      1-cycle pulse: dt_meas_B updated
//  dt_viol_A    out  1      sticky: a gap before A-on was < dtmin_A
//  dt_viol_B    out  1      sticky: a gap before B-on was < dtmin_B
//  shoot_thru   out  1      sticky: A and B both active in same cycle
//  fault        out  1      dt_viol_A | dt_viol_B | shoot_thru (comb)
//  period       out  PER_W  cycles between successive pwm_rec rising edges
//  high_time    out  PER_W  pwm_rec high cycles of that period
//  period_valid out  1      1-cycle pulse: period/high_time updated
// BEHAVIOUR
//  - Reset: every output and counter 0, FSM ST_OFF. Reset mid-operation discards partial measurements.
//  - Gates pass through SYNC_STAGES flops, then polarity XOR -> actA/actB. All timing is in synced domain.
//  - Latency: pin edge -> dt_valid/fault/pwm_rec change = SYNC_STAGES+1 clk.
//  - FSM (mon_state_t): ST_OFF, ST_SYNC, ST_A_ON, ST_DT_AB, ST_B_ON, ST_DT_BA.
//    ST_OFF: pwm_onoff on -> ST_SYNC. pwm_onoff off in any state -> ST_OFF, counters 0, pwm_rec 0.
//    ST_SYNC: actA&!actB -> ST_A_ON; actB&!actA -> ST_B_ON; no measurement.
//    ST_A_ON: !actA&!actB -> ST_DT_AB, dtcnt=1, pwm_rec<=0.
//    ST_DT_AB: both idle -> dtcnt++ (saturates at 2^CNT_W-1); actB only -> dt_meas_B=dtcnt, dt_valid_B,
//      dt_viol_B set if dtcnt<dtmin_B, ->ST_B_ON; actA only -> ST_A_ON, no measurement, pwm_rec<=1.
//    ST_B_ON / ST_DT_BA: mirror (gap before A-on); leaving ST_B_ON sets pwm_rec<=1.
//    Any enabled state (not ST_OFF): actA&actB -> shoot_thru set, ->ST_SYNC.
//  - Direct A<->B swap in one cycle (no idle cycle) = gap 0: dt_meas=0, dt_valid pulses, viol if dtmin>0.
//  - A gap of N clk with both inactive reports N. Dead-time stage with dtime=d reports d.
//  - Sticky flags: set has priority over fault_clr in same cycle. fault_clr while off clears normally.
//  - Period: counts from each pwm_rec rise. On next rise: period=count, high_time=high count, period_valid.
//    First rise after enable only arms. Counters saturate at 2^PER_W-1; saturated value is reported.
// STRUCTURE
//  - Shared package pwm_pkg: existing _pwm_onoff; add mon_state_t enum.
//  - One sub-module: gate_sync (SYNC_STAGES-deep bit synchronizer, reset 0), instantiated for gate_A and gate_B.
//  - Rest in one always_ff (FSM, counters, flags) plus comb fault. Nonblocking assignments only.
// TESTING
//  1. Enable, logic_A=logic_B=0, A high 20, both low 5, B high 20, both low 7, repeat
//     -> dt_meas_B=5, dt_meas_A=7, each dt_valid 1 pulse, no faults.
//  2. dtmin_B=6, same stimulus as 1 -> dt_viol_B=1, fault=1 held. fault_clr pulse -> 0.
//     Clear in same cycle as new violation -> stays 1.
//  3. Force A and B high together 1 cycle -> shoot_thru=1, FSM ST_SYNC, resumes measurement on next clean edge.
//  4. Loopback from dead-time stage: dtime_A=dtime_B=4, 50% PWM period 100
//     -> dt_meas_A=dt_meas_B=4, period=100, high_time=50, pwm_rec matches PWM delayed.
//  5. Gap 300 cycles with CNT_W=8 -> dt_meas=255. Inverted logic_A=1 with inverted gate_A -> same results as 1.
//  6. Assert reset mid ST_DT_AB, and toggle pwm_onoff off mid-period
//     -> all outputs 0, no dt_valid/period_valid, no fault on re-enable.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions.
//   _pwm_onoff  : enable type used by all PWM blocks (on = block running)
//   mon_state_t : state encoding of the gate pair monitor
package pwm_pkg;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_SYNC  = 3'd1,
    ST_A_ON  = 3'd2,
    ST_DT_AB = 3'd3,
    ST_B_ON  = 3'd4,
    ST_DT_BA = 3'd5
  } mon_state_t;

endpackage

// File: rtl/gate_sync.sv
// Multi-stage bit synchronizer for one asynchronous gate pin.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous, active-high; clears every stage to 0
//   din   in  raw asynchronous input
//   dout  out synchronized copy of din, STAGES clocks later
module gate_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] stage;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage[gi] <= 1'b0;
          else       stage[gi] <= din;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage[gi] <= 1'b0;
          else       stage[gi] <= stage[gi-1];
        end
      end
    end
  endgenerate

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/gate_pair_monitor.sv
// Receive-side checker for a complementary gate pair (A = high side,
// B = low side). Recovers the PWM, measures every dead-time gap, times
// period / high time and flags dead-time violations and shoot-through.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   gate_A, gate_B        raw gate pins (async), synchronized internally
//   logic_A, logic_B      pin polarity: active = gate ^ logic
//   pwm_onoff             monitor enable; off forces idle and clears measurements
//   dtmin_A, dtmin_B      minimum legal gap before A-on / B-on (cycles)
//   fault_clr             clears sticky fault flags (a set in the same cycle wins)
//   pwm_rec               recovered PWM
//   dt_meas_A/B, dt_valid_A/B   last gap before A-on / B-on and update pulses
//   dt_viol_A/B, shoot_thru, fault   sticky faults and their OR
//   period, high_time, period_valid  PWM timing between pwm_rec rises
module gate_pair_monitor
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int PER_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gate_A,
  input  logic             gate_B,
  input  logic             logic_A,
  input  logic             logic_B,
  input  _pwm_onoff        pwm_onoff,
  input  logic [CNT_W-1:0] dtmin_A,
  input  logic [CNT_W-1:0] dtmin_B,
  input  logic             fault_clr,
  output logic             pwm_rec,
  output logic [CNT_W-1:0] dt_meas_A,
  output logic [CNT_W-1:0] dt_meas_B,
  output logic             dt_valid_A,
  output logic             dt_valid_B,
  output logic             dt_viol_A,
  output logic             dt_viol_B,
  output logic             shoot_thru,
  output logic             fault,
  output logic [PER_W-1:0] period,
  output logic [PER_W-1:0] high_time,
  output logic             period_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  logic sync_a;
  logic sync_b;
  logic act_a;
  logic act_b;

  mon_state_t       state;
  logic [CNT_W-1:0] dt_cnt;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] hi_cnt;
  logic             rec_d;   // pwm_rec one cycle ago, for rise detection
  logic             armed;   // a first rise has been seen since enable

  gate_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .din   (gate_A),
    .dout  (sync_a)
  );

  gate_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .din   (gate_B),
    .dout  (sync_b)
  );

  assign act_a = sync_a ^ logic_A;
  assign act_b = sync_b ^ logic_B;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_OFF;
      dt_cnt       <= '0;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      rec_d        <= 1'b0;
      armed        <= 1'b0;
      pwm_rec      <= 1'b0;
      dt_meas_A    <= '0;
      dt_meas_B    <= '0;
      dt_valid_A   <= 1'b0;
      dt_valid_B   <= 1'b0;
      dt_viol_A    <= 1'b0;
      dt_viol_B    <= 1'b0;
      shoot_thru   <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
    end else begin
      dt_valid_A   <= 1'b0;
      dt_valid_B   <= 1'b0;
      period_valid <= 1'b0;

      // Clear first; any flag set further down overrides it.
      if (fault_clr) begin
        dt_viol_A  <= 1'b0;
        dt_viol_B  <= 1'b0;
        shoot_thru <= 1'b0;
      end

      if (pwm_onoff != PWM_ON) begin
        state     <= ST_OFF;
        dt_cnt    <= '0;
        per_cnt   <= '0;
        hi_cnt    <= '0;
        rec_d     <= 1'b0;
        armed     <= 1'b0;
        pwm_rec   <= 1'b0;
        dt_meas_A <= '0;
        dt_meas_B <= '0;
        period    <= '0;
        high_time <= '0;
      end else begin
        // Period / high time, measured on the registered pwm_rec.
        rec_d <= pwm_rec;
        if (pwm_rec && !rec_d) begin
          if (armed) begin
            period       <= per_cnt;
            high_time    <= hi_cnt;
            period_valid <= 1'b1;
          end
          armed   <= 1'b1;
          per_cnt <= PER_ONE;
          hi_cnt  <= PER_ONE;
        end else begin
          if (per_cnt != PER_MAX) per_cnt <= per_cnt + PER_ONE;
          if (pwm_rec && hi_cnt != PER_MAX) hi_cnt <= hi_cnt + PER_ONE;
        end

        if (state != ST_OFF && act_a && act_b) begin
          shoot_thru <= 1'b1;
          state      <= ST_SYNC;
        end else begin
          case (state)
            ST_OFF: state <= ST_SYNC;

            ST_SYNC: begin
              if (act_a) begin
                state   <= ST_A_ON;
                pwm_rec <= 1'b1;
              end else if (act_b) begin
                state   <= ST_B_ON;
                pwm_rec <= 1'b0;
              end
            end

            ST_A_ON: begin
              if (!act_a && !act_b) begin
                state   <= ST_DT_AB;
                dt_cnt  <= CNT_ONE;
                pwm_rec <= 1'b0;
              end else if (act_b) begin
                // Swap with no idle cycle: a zero-length gap.
                state      <= ST_B_ON;
                pwm_rec    <= 1'b0;
                dt_meas_B  <= '0;
                dt_valid_B <= 1'b1;
                if (dtmin_B != '0) dt_viol_B <= 1'b1;
              end
            end

            ST_DT_AB: begin
              if (!act_a && !act_b) begin
                if (dt_cnt != CNT_MAX) dt_cnt <= dt_cnt + CNT_ONE;
              end else if (act_b) begin
                state      <= ST_B_ON;
                dt_meas_B  <= dt_cnt;
                dt_valid_B <= 1'b1;
                if (dt_cnt < dtmin_B) dt_viol_B <= 1'b1;
              end else begin
                // A came back without B ever turning on.
                state   <= ST_A_ON;
                pwm_rec <= 1'b1;
              end
            end

            ST_B_ON: begin
              if (!act_a && !act_b) begin
                state   <= ST_DT_BA;
                dt_cnt  <= CNT_ONE;
                pwm_rec <= 1'b1;
              end else if (act_a) begin
                state      <= ST_A_ON;
                pwm_rec    <= 1'b1;
                dt_meas_A  <= '0;
                dt_valid_A <= 1'b1;
                if (dtmin_A != '0) dt_viol_A <= 1'b1;
              end
            end

            ST_DT_BA: begin
              if (!act_a && !act_b) begin
                if (dt_cnt != CNT_MAX) dt_cnt <= dt_cnt + CNT_ONE;
              end else if (act_a) begin
                state      <= ST_A_ON;
                dt_meas_A  <= dt_cnt;
                dt_valid_A <= 1'b1;
                if (dt_cnt < dtmin_A) dt_viol_A <= 1'b1;
              end else begin
                state   <= ST_B_ON;
                pwm_rec <= 1'b0;
              end
            end

            default: state <= ST_OFF;
          endcase
        end
      end
    end
  end

  assign fault = dt_viol_A | dt_viol_B | shoot_thru;

endmodule

// File: tb/tb_gate_pair_monitor.sv
// Directed bench for gate_pair_monitor: gate patterns with hand-computed
// gaps, periods and fault behaviour; one line per measured transaction.
module tb_gate_pair_monitor;
  import pwm_pkg::*;

  localparam int CNT_W = 8;
  localparam int PER_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             gate_A = 1'b0;
  logic             gate_B = 1'b0;
  logic             logic_A = 1'b0;
  logic             logic_B = 1'b0;
  _pwm_onoff        pwm_onoff = PWM_OFF;
  logic [CNT_W-1:0] dtmin_A = '0;
  logic [CNT_W-1:0] dtmin_B = '0;
  logic             fault_clr = 1'b0;
  logic             pwm_rec;
  logic [CNT_W-1:0] dt_meas_A;
  logic [CNT_W-1:0] dt_meas_B;
  logic             dt_valid_A;
  logic             dt_valid_B;
  logic             dt_viol_A;
  logic             dt_viol_B;
  logic             shoot_thru;
  logic             fault;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] high_time;
  logic             period_valid;

  gate_pair_monitor #(.CNT_W(CNT_W), .PER_W(PER_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .gate_A       (gate_A),
    .gate_B       (gate_B),
    .logic_A      (logic_A),
    .logic_B      (logic_B),
    .pwm_onoff    (pwm_onoff),
    .dtmin_A      (dtmin_A),
    .dtmin_B      (dtmin_B),
    .fault_clr    (fault_clr),
    .pwm_rec      (pwm_rec),
    .dt_meas_A    (dt_meas_A),
    .dt_meas_B    (dt_meas_B),
    .dt_valid_A   (dt_valid_A),
    .dt_valid_B   (dt_valid_B),
    .dt_viol_A    (dt_viol_A),
    .dt_viol_B    (dt_viol_B),
    .shoot_thru   (shoot_thru),
    .fault        (fault),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Transaction log collected on the falling edge.
  int nv_a, nv_b, npv;
  int min_a, max_a, min_b, max_b;
  int last_per, last_hi;

  task automatic clear_mon();
    nv_a = 0; nv_b = 0; npv = 0;
    min_a = 999999; max_a = -1;
    min_b = 999999; max_b = -1;
    last_per = -1; last_hi = -1;
  endtask

  always @(negedge clk) begin
    if (dt_valid_A) begin
      nv_a = nv_a + 1;
      if (int'(dt_meas_A) < min_a) min_a = int'(dt_meas_A);
      if (int'(dt_meas_A) > max_a) max_a = int'(dt_meas_A);
      $display("[%0t] gap before A-on: %0d", $time, dt_meas_A);
    end
    if (dt_valid_B) begin
      nv_b = nv_b + 1;
      if (int'(dt_meas_B) < min_b) min_b = int'(dt_meas_B);
      if (int'(dt_meas_B) > max_b) max_b = int'(dt_meas_B);
      $display("[%0t] gap before B-on: %0d", $time, dt_meas_B);
    end
    if (period_valid) begin
      npv = npv + 1;
      last_per = int'(period);
      last_hi  = int'(high_time);
      $display("[%0t] period %0d high %0d", $time, period, high_time);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive active levels a/b on the pins (through the polarity) for n cycles.
  task automatic seg(input logic a, input logic b, input int n);
    gate_A = a ^ logic_A;
    gate_B = b ^ logic_B;
    cyc(n);
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
  endtask

  // B20, gap 7, A20, gap 5, repeated; ends with B held.
  task automatic pattern1(input int reps);
    for (int r = 0; r < reps; r++) begin
      seg(0, 1, 20);
      seg(0, 0, 7);
      seg(1, 0, 20);
      seg(0, 0, 5);
    end
    seg(0, 1, 6);
  endtask

  task automatic t1_checks(input string p);
    check({p, "nv_a"},  nv_a, 3);
    check({p, "min_a"}, min_a, 7);
    check({p, "max_a"}, max_a, 7);
    check({p, "nv_b"},  nv_b, 3);
    check({p, "min_b"}, min_b, 5);
    check({p, "max_b"}, max_b, 5);
    check({p, "npv"},   npv, 2);
    check({p, "period"}, last_per, 52);
    check({p, "high"},  last_hi, 27);
    check({p, "fault"}, fault, 0);
  endtask

  initial begin
    clear_mon();
    cyc(3);
    check("rst pwm_rec", pwm_rec, 0);
    check("rst dt_meas_A", dt_meas_A, 0);
    check("rst period", period, 0);
    check("rst fault", fault, 0);
    reset = 1'b0;
    cyc(5);

    // 1: basic gaps and period
    clear_mon();
    pwm_onoff = PWM_ON;
    pattern1(3);
    t1_checks("t1 ");

    // 2: dead-time violation, clear, clear colliding with a new violation
    dtmin_B = 8'd6;
    clear_mon();
    seg(0, 0, 7);
    seg(1, 0, 20);
    seg(0, 0, 5);
    seg(0, 1, 10);
    check("t2 viol_B", dt_viol_B, 1);
    check("t2 viol_A", dt_viol_A, 0);
    check("t2 fault", fault, 1);
    check("t2 dt_meas_B", dt_meas_B, 5);
    cyc(10);
    check("t2 fault held", fault, 1);
    pulse_clr();
    check("t2 cleared viol_B", dt_viol_B, 0);
    check("t2 cleared fault", fault, 0);
    seg(0, 0, 7);
    seg(1, 0, 20);
    seg(0, 0, 5);
    gate_A = 1'b0 ^ logic_A;
    gate_B = 1'b1 ^ logic_B;
    cyc(2);
    check("t2 valid_B early", dt_valid_B, 0);
    check("t2 viol_B early", dt_viol_B, 0);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    check("t2 valid_B latency", dt_valid_B, 1);
    check("t2 set beats clr", dt_viol_B, 1);
    cyc(5);

    // 3: shoot-through
    dtmin_B = 8'd0;
    pulse_clr();
    check("t3 pre fault", fault, 0);
    clear_mon();
    seg(1, 1, 1);
    seg(0, 1, 8);
    check("t3 shoot_thru", shoot_thru, 1);
    check("t3 fault", fault, 1);
    check("t3 no meas a", nv_a, 0);
    check("t3 no meas b", nv_b, 0);
    seg(0, 0, 7);
    seg(1, 0, 6);
    check("t3 resume nv_a", nv_a, 1);
    check("t3 resume meas", dt_meas_A, 7);

    // 4: dead-time stage loopback, dtime 4, period 100, 50%
    pulse_clr();
    check("t4 shoot cleared", shoot_thru, 0);
    clear_mon();
    seg(1, 0, 40);
    seg(0, 0, 4);
    seg(0, 1, 46);
    for (int k = 0; k < 3; k++) begin
      gate_A = 1'b0 ^ logic_A;
      gate_B = 1'b0 ^ logic_B;
      cyc(2);
      check("t4 rec before rise", pwm_rec, 0);
      cyc(1);
      check("t4 rec after rise", pwm_rec, 1);
      cyc(1);
      seg(1, 0, 46);
      gate_A = 1'b0 ^ logic_A;
      gate_B = 1'b0 ^ logic_B;
      cyc(2);
      check("t4 rec before fall", pwm_rec, 1);
      cyc(1);
      check("t4 rec after fall", pwm_rec, 0);
      cyc(1);
      seg(0, 1, 46);
    end
    seg(0, 1, 6);
    check("t4 nv_a", nv_a, 3);
    check("t4 nv_b", nv_b, 4);
    check("t4 min_a", min_a, 4);
    check("t4 max_a", max_a, 4);
    check("t4 min_b", min_b, 4);
    check("t4 max_b", max_b, 4);
    check("t4 npv", npv, 3);
    check("t4 period", last_per, 100);
    check("t4 high", last_hi, 50);
    check("t4 fault", fault, 0);

    // 5: gap saturation, then inverted A polarity
    clear_mon();
    seg(0, 0, 300);
    seg(1, 0, 6);
    check("t5 nv_a", nv_a, 1);
    check("t5 sat", dt_meas_A, 255);
    check("t5 viol_A", dt_viol_A, 0);
    pwm_onoff = PWM_OFF;
    cyc(2);
    check("t5 off dt_meas_A", dt_meas_A, 0);
    check("t5 off pwm_rec", pwm_rec, 0);
    check("t5 off period", period, 0);
    logic_A = 1'b1;
    seg(0, 0, 5);
    clear_mon();
    pwm_onoff = PWM_ON;
    pattern1(3);
    t1_checks("t5inv ");

    // 6: reset in the middle of a gap, then disable mid-period
    pwm_onoff = PWM_OFF;
    logic_A = 1'b0;
    seg(0, 0, 5);
    dtmin_A = 8'd10;
    clear_mon();
    pwm_onoff = PWM_ON;
    seg(0, 1, 20);
    seg(0, 0, 7);
    seg(1, 0, 20);
    seg(0, 0, 6);
    check("t6 viol_A", dt_viol_A, 1);
    check("t6 nv_a", nv_a, 1);
    reset = 1'b1;
    #2;
    check("t6 async dt_meas_A", dt_meas_A, 0);
    check("t6 async viol_A", dt_viol_A, 0);
    check("t6 async fault", fault, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dtmin_A = 8'd0;
    clear_mon();
    seg(0, 0, 4);
    seg(0, 1, 10);
    check("t6 rst nv_a", nv_a, 0);
    check("t6 rst nv_b", nv_b, 0);
    check("t6 rst npv", npv, 0);
    check("t6 rst fault", fault, 0);
    check("t6 rst dt_meas_B", dt_meas_B, 0);
    seg(0, 0, 7);
    seg(1, 0, 10);
    check("t6 rec high", pwm_rec, 1);
    pwm_onoff = PWM_OFF;
    cyc(2);
    check("t6 off pwm_rec", pwm_rec, 0);
    check("t6 off dt_meas_A", dt_meas_A, 0);
    clear_mon();
    pwm_onoff = PWM_ON;
    seg(1, 0, 10);
    seg(0, 0, 5);
    seg(0, 1, 10);
    check("t6 reen npv", npv, 0);
    check("t6 reen fault", fault, 0);
    check("t6 reen nv_b", nv_b, 1);
    check("t6 reen dt_meas_B", dt_meas_B, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
